// File: rtl/demultiplexor_1a4.sv
// Registered 1-to-4 demultiplexer: X steered to A/B/C/D by Selector, others zeroed.
// Optional macro DEMUX_SEL_ERR_EN adds a registered out-of-range Error flag.

module demux_lane #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             hit,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (en)
            q <= hit ? x : '0;
    end

endmodule

module demultiplexor_1a4 #(
    parameter int WIDTH     = 4,
    parameter int SEL_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 En,
    input  logic [WIDTH-1:0]     X,
    input  logic [SEL_WIDTH-1:0] Selector,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     B,
    output logic [WIDTH-1:0]     C,
    output logic [WIDTH-1:0]     D
`ifdef DEMUX_SEL_ERR_EN
    ,
    output logic                 Error
`endif
);

    logic [3:0]            sel_hit;
    logic [3:0][WIDTH-1:0] ch_q;

    // Full-width compare so codes >= 4 never alias onto a lane.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign sel_hit[i] = (Selector == SEL_WIDTH'(i));

        demux_lane #(.WIDTH(WIDTH)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (En),
            .hit   (sel_hit[i]),
            .x     (X),
            .q     (ch_q[i])
        );
    end

    assign A = ch_q[0];
    assign B = ch_q[1];
    assign C = ch_q[2];
    assign D = ch_q[3];

`ifdef DEMUX_SEL_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            Error <= 1'b0;
        else if (En)
            Error <= ~|sel_hit;
    end
`endif

endmodule

// File: tb/tb_demultiplexor_1a4.sv
// Directed + randomized bench for demultiplexor_1a4 against a per-channel array model.

module tb_demultiplexor_1a4;

    int checks = 0;
    int errors = 0;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [3:0] x     = '0;
    logic [2:0] sel   = '0;
    logic [3:0] a, b, c, d;

    logic [7:0] x8    = '0;
    logic [1:0] sel8  = '0;
    logic [7:0] a8, b8, c8, d8;

    logic [3:0] exp_q [4];
    logic       exp_err;
    logic [7:0] exp8  [4];

`ifdef DEMUX_SEL_ERR_EN
    logic err, err8;
`endif

    always #5 clk = ~clk;

    demultiplexor_1a4 #(.WIDTH(4), .SEL_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .En(en), .X(x), .Selector(sel),
        .A(a), .B(b), .C(c), .D(d)
`ifdef DEMUX_SEL_ERR_EN
        , .Error(err)
`endif
    );

    demultiplexor_1a4 #(.WIDTH(8), .SEL_WIDTH(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .En(1'b1), .X(x8), .Selector(sel8),
        .A(a8), .B(b8), .C(c8), .D(d8)
`ifdef DEMUX_SEL_ERR_EN
        , .Error(err8)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_A"}, {4'h0, a}, {4'h0, exp_q[0]});
        chk({tag, "_B"}, {4'h0, b}, {4'h0, exp_q[1]});
        chk({tag, "_C"}, {4'h0, c}, {4'h0, exp_q[2]});
        chk({tag, "_D"}, {4'h0, d}, {4'h0, exp_q[3]});
`ifdef DEMUX_SEL_ERR_EN
        chk({tag, "_Err"}, {7'h0, err}, {7'h0, exp_err});
`endif
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            exp_q[i] = '0;
            exp8[i]  = '0;
        end
        exp_err = 1'b0;
    endtask

    // Reference: on an enabled edge the addressed channel gets X, the rest 0.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (en) begin
                for (int i = 0; i < 4; i++)
                    exp_q[i] = (int'(sel) == i) ? x : 4'h0;
                exp_err = (int'(sel) > 3);
            end
            for (int i = 0; i < 4; i++)
                exp8[i] = (int'(sel8) == i) ? x8 : 8'h00;
        end
        #1;
    endtask

    initial begin
        clear_model();

        // Reset state
        #12;
        chk_all("reset");
        rst_n = 1'b1;

        // Sweep all four channels
        en = 1'b1; x = 4'b1011;
        for (int s = 0; s < 4; s++) begin
            sel = 3'(s);
            tick();
            chk_all($sformatf("sweep%0d", s));
        end

        // Out-of-range codes, then back in range
        sel = 3'd4; tick(); chk_all("oor4");
        sel = 3'd5; tick(); chk_all("oor5");
        sel = 3'd0; tick(); chk_all("oor_back0");

        // Hold with En low
        sel = 3'd2; x = 4'b1011; tick(); chk_all("hold_load");
        en = 1'b0; x = 4'b0110; sel = 3'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("hold%0d", i));
        end

        // Latency: outputs only move on the edge
        en = 1'b1; sel = 3'd3; x = 4'b1011; tick(); chk_all("lat_load");
        x = 4'b0001;
        #3 chk_all("lat_between");
        tick(); chk_all("lat_next");

        // Asynchronous reset mid-cycle
        sel = 3'd0; x = 4'b1011; tick(); chk_all("mid_load");
        #2 rst_n = 1'b0;
        #1 clear_model();
        chk_all("mid_reset");
        tick(); chk_all("reset_held1");
        tick(); chk_all("reset_held2");
        #3 rst_n = 1'b1;
        sel = 3'd1; tick(); chk_all("post_reset");

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            en  = 1'($urandom_range(0, 3) != 0);
            x   = 4'($urandom);
            sel = 3'($urandom);
            tick();
            chk_all($sformatf("rnd%0d", n));
        end

        // Narrow-selector, wide-data instance
        x8 = 8'hA5; sel8 = 2'b01; tick();
        chk("w8_A", a8, exp8[0]); chk("w8_B", b8, exp8[1]);
        chk("w8_C", c8, exp8[2]); chk("w8_D", d8, exp8[3]);
        chk("w8_B_const", b8, 8'hA5);
        x8 = 8'h3C; sel8 = 2'b11; tick();
        chk("w8b_A", a8, exp8[0]); chk("w8b_B", b8, exp8[1]);
        chk("w8b_C", c8, exp8[2]); chk("w8b_D", d8, exp8[3]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
